controller_led_pio: RTL



---
 rtl/controller_led_pkg.sv | 13 +
 rtl/controller_led_blink_timer.sv | 38 +++
 rtl/controller_led_pio.sv | 112 +++++++++++
 3 files changed

// File: rtl/controller_led_pkg.sv
// Shared register map and PWM constants for the LED PIO controller.
package controller_led_pkg;
    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_MASK   = 3'd3;
    localparam logic [2:0] ADDR_DIV    = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;
    localparam logic [2:0] ADDR_DUTY   = 3'd6;

    localparam int PWM_W = 8;
    localparam logic [PWM_W-1:0] DUTY_RESET = 8'hFF;
endpackage

// File: rtl/controller_led_blink_timer.sv
// Blink divider: phase toggles every div+1 cycles; a div write restarts the period at phase 0.
module controller_led_blink_timer #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic             div_wr,
    output logic             phase
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + DIV_W'(1);
        phase_d = phase_q;
        // A divider write wins over a coincident terminal count.
        if (div_wr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == div) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
endmodule

// File: rtl/controller_led_pio.sv
// Avalon-MM LED output port with set/clear, per-bit blink and (CONTROLLER_LED_PIO_PWM_EN) a global PWM dimmer.
// Zero-wait-state slave: registers update on the write edge, readdata is a combinational mux.
module controller_led_pio
    import controller_led_pkg::*;
#(
    parameter int               WIDTH       = 10,
    parameter int               DIV_W       = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             blink_phase
);
    logic             wr;
    logic             div_wr;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [WIDTH-1:0] blink_out;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign div_wr    = wr && (address == ADDR_DIV);
    assign unused_wd = ^writedata;

    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        div_d  = div_q;
        if (wr) begin
            case (address)
                ADDR_DATA:  data_d = writedata[WIDTH-1:0];
                ADDR_SET:   data_d = data_q | writedata[WIDTH-1:0];
                ADDR_CLEAR: data_d = data_q & ~writedata[WIDTH-1:0];
                ADDR_MASK:  mask_d = writedata[WIDTH-1:0];
                ADDR_DIV:   div_d  = writedata[DIV_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
            mask_q <= '0;
            div_q  <= '0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            div_q  <= div_d;
        end
    end

    controller_led_blink_timer #(
        .DIV_W (DIV_W)
    ) u_blink_timer (
        .clk    (clk),
        .reset  (reset),
        .div    (div_d),
        .div_wr (div_wr),
        .phase  (blink_phase)
    );

    // Masked bits are lit only during phase 1.
    assign blink_out = data_q & (~mask_q | {WIDTH{blink_phase}});

`ifdef CONTROLLER_LED_PIO_PWM_EN
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [PWM_W-1:0] pwm_cnt_q;
    logic             pwm_on;

    always_comb begin
        duty_d = duty_q;
        if (wr && (address == ADDR_DUTY)) duty_d = writedata[PWM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q    <= DUTY_RESET;
            pwm_cnt_q <= '0;
        end else begin
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
        end
    end

    assign pwm_on   = (duty_q == {PWM_W{1'b1}}) | (pwm_cnt_q < duty_q);
    assign out_port = blink_out & {WIDTH{pwm_on}};
`else
    assign out_port = blink_out;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_q);
            ADDR_MASK:   readdata = 32'(mask_q);
            ADDR_DIV:    readdata = 32'(div_q);
            ADDR_STATUS: readdata = {31'b0, blink_phase};
`ifdef CONTROLLER_LED_PIO_PWM_EN
            ADDR_DUTY:   readdata = 32'(duty_q);
`endif
            default:     readdata = '0;
        endcase
    end
endmodule
